// File: rtl/mult_share_arb.sv
// mult_share_arb: two requesters share a single combinational multiplier.
// A round-robin grant in IDLE accepts one operand pair. The pair is
// multiplied in CALC, and the product is presented in RESP until the
// owning requester takes it.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   reqX_valid/_m/_q      operand request from requester X (X = 0, 1)
//   reqX_ready            operands accepted this cycle
//   rspX_valid/_p         product for requester X (p is 0 while not valid)
//   rspX_ready            requester X takes the product

// mult4x4: combinational unsigned multiplier, full-width product.
//   m, q : operands (N bits)
//   P    : product (2N bits)
module mult4x4 #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]   m,
    input  logic [N-1:0]   q,
    output logic [2*N-1:0] P
);
    assign P = {{N{1'b0}}, m} * {{N{1'b0}}, q};
endmodule

module mult_share_arb #(
    parameter int unsigned N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    input  logic [N-1:0]   req0_m,
    input  logic [N-1:0]   req0_q,
    output logic           req0_ready,
    output logic           rsp0_valid,
    output logic [2*N-1:0] rsp0_p,
    input  logic           rsp0_ready,
    input  logic           req1_valid,
    input  logic [N-1:0]   req1_m,
    input  logic [N-1:0]   req1_q,
    output logic           req1_ready,
    output logic           rsp1_valid,
    output logic [2*N-1:0] rsp1_p,
    input  logic           rsp1_ready
);
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t         state_q;
    logic           last_grant_q;
    logic           owner_q;
    logic           post_rst_q;
    logic [N-1:0]   opm_q;
    logic [N-1:0]   opq_q;
    logic [2*N-1:0] res_q;
    logic [1:0]     rsp_valid_q;
    logic [2*N-1:0] prod;
    logic           quiet;
    logic           gnt_valid;
    logic           gnt_id;
    logic           owner_ready;

    mult4x4 #(.N(N)) u_mult (
        .m(opm_q),
        .q(opq_q),
        .P(prod)
    );

    // Handshake outputs are held low during reset and the cycle after it.
    assign quiet = rst | post_rst_q;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
        if (state_q == IDLE && !quiet) begin
            if (req0_valid && req1_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = ~last_grant_q;
            end else if (req0_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b0;
            end else if (req1_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = 1'b1;
            end
        end
    end

    assign req0_ready  = gnt_valid & ~gnt_id;
    assign req1_ready  = gnt_valid &  gnt_id;
    assign owner_ready = owner_q ? rsp1_ready : rsp0_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            post_rst_q   <= 1'b1;
            opm_q        <= '0;
            opq_q        <= '0;
            res_q        <= '0;
            rsp_valid_q  <= '0;
        end else begin
            post_rst_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A grant implies the granted requester is valid, so it is the accept.
                    if (gnt_valid) begin
                        opm_q        <= gnt_id ? req1_m : req0_m;
                        opq_q        <= gnt_id ? req1_q : req0_q;
                        owner_q      <= gnt_id;
                        last_grant_q <= gnt_id;
                        state_q      <= CALC;
                    end
                end
                CALC: begin
                    res_q       <= prod;
                    rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (owner_ready) begin
                        rsp_valid_q <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= '0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign rsp0_valid = rsp_valid_q[0] & ~rst;
    assign rsp1_valid = rsp_valid_q[1] & ~rst;
    assign rsp0_p     = rsp0_valid ? res_q : '0;
    assign rsp1_p     = rsp1_valid ? res_q : '0;
endmodule
